// File: rtl/math_display_scan.sv
// Snapshot register plus four-digit multiplexed 7-segment scanner for the
// 4-bit add/subtract stage; every output is registered.
module math_display_scan #(
   parameter int REFRESH_DIV = 4,
   parameter bit ACTIVE_LOW  = 1'b1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       load,
   input  logic [3:0] a_in,
   input  logic [3:0] b_in,
   input  logic [3:0] sum_in,
   input  logic [3:0] diff_in,
   input  logic       blank,
   output logic [6:0] seg,
   output logic [3:0] an
);

   localparam int            CW      = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [CW-1:0] DIV_MAX = CW'(REFRESH_DIV - 1);
   localparam logic [6:0]    SEG_OFF = ACTIVE_LOW ? 7'h7F : 7'h00;
   localparam logic [3:0]    AN_OFF  = ACTIVE_LOW ? 4'hF : 4'h0;

   function automatic logic [6:0] hex_decode(input logic [3:0] v);
      logic [6:0] s;
      case (v)
         4'h0:    s = 7'h3F;
         4'h1:    s = 7'h06;
         4'h2:    s = 7'h5B;
         4'h3:    s = 7'h4F;
         4'h4:    s = 7'h66;
         4'h5:    s = 7'h6D;
         4'h6:    s = 7'h7D;
         4'h7:    s = 7'h07;
         4'h8:    s = 7'h7F;
         4'h9:    s = 7'h6F;
         4'hA:    s = 7'h77;
         4'hB:    s = 7'h7C;
         4'hC:    s = 7'h39;
         4'hD:    s = 7'h5E;
         4'hE:    s = 7'h79;
         4'hF:    s = 7'h71;
         default: s = 7'h00;
      endcase
      return s;
   endfunction

   logic [CW-1:0] div_cnt_q, div_cnt_d;
   logic [1:0]    digit_idx_q, digit_idx_d;
   logic [15:0]   snap_q, snap_d;        // {a, b, sum, diff}
   logic [6:0]    seg_q, seg_d;
   logic [3:0]    an_q, an_d;
   logic [3:0]    nibble_s;
   logic [6:0]    seg_on_s;
   logic [3:0]    an_on_s;

   // Next-state for refresh counter, scanner and snapshot.
   always_comb begin
      div_cnt_d   = div_cnt_q;
      digit_idx_d = digit_idx_q;
      snap_d      = snap_q;
      if (div_cnt_q == DIV_MAX) begin
         div_cnt_d   = '0;
         digit_idx_d = digit_idx_q + 2'd1;
      end else begin
         div_cnt_d   = div_cnt_q + CW'(1);
      end
      if (load) begin
         snap_d = {a_in, b_in, sum_in, diff_in};
      end else begin
         snap_d = snap_q;
      end
   end

   // Output decode; the first cycle of every slot is dark so the previous
   // digit's segments never ghost onto the newly enabled anode.
   always_comb begin
      nibble_s = 4'h0;
      seg_on_s = 7'h00;
      an_on_s  = 4'h0;
      case (digit_idx_q)
         2'd0:    nibble_s = snap_q[3:0];
         2'd1:    nibble_s = snap_q[7:4];
         2'd2:    nibble_s = snap_q[11:8];
         2'd3:    nibble_s = snap_q[15:12];
         default: nibble_s = 4'h0;
      endcase
      if (blank || (div_cnt_q == '0)) begin
         seg_on_s = 7'h00;
         an_on_s  = 4'h0;
      end else begin
         seg_on_s = hex_decode(nibble_s);
         an_on_s  = 4'b0001 << digit_idx_q;
      end
      seg_d = ACTIVE_LOW ? ~seg_on_s : seg_on_s;
      an_d  = ACTIVE_LOW ? ~an_on_s  : an_on_s;
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt_q   <= '0;
         digit_idx_q <= 2'd0;
         snap_q      <= 16'h0000;
         seg_q       <= SEG_OFF;
         an_q        <= AN_OFF;
      end else begin
         div_cnt_q   <= div_cnt_d;
         digit_idx_q <= digit_idx_d;
         snap_q      <= snap_d;
         seg_q       <= seg_d;
         an_q        <= an_d;
      end
   end

   assign seg = seg_q;
   assign an  = an_q;

endmodule

// File: tb/tb_math_display_scan.sv
// Randomised bench for math_display_scan against a cycle-count reference model,
// with hand-computed literal checks for the documented scenarios.
module tb_math_display_scan;

   logic       clk, rst_n, load, blank;
   logic [3:0] a_in, b_in, sum_in, diff_in;
   logic [6:0] seg;
   logic [3:0] an;

   math_display_scan #(.REFRESH_DIV(4), .ACTIVE_LOW(1'b1)) dut (
      .clk(clk), .rst_n(rst_n), .load(load), .a_in(a_in), .b_in(b_in),
      .sum_in(sum_in), .diff_in(diff_in), .blank(blank), .seg(seg), .an(an)
   );

   always #5 clk = ~clk;

   // Reference: position in the scan is just the number of edges since reset.
   logic [6:0] dec_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
   logic [3:0] snap [4];   // indexed by digit: 0=diff 1=sum 2=B 3=A
   int cyc, last_c;
   int vectors, errs;
   logic [6:0] got_seg;
   logic [3:0] got_an;

   function automatic logic [10:0] model_out(input int c, input logic bl);
      int div, idx;
      logic [3:0] one_hot;
      div = c % 4;
      idx = (c / 4) % 4;
      if (bl || div == 0) return {7'h7F, 4'hF};
      one_hot = 4'b0001 << idx;
      return {~dec_tab[snap[idx]], ~one_hot};
   endfunction

   task automatic chk(input string name, input logic [10:0] act, input logic [10:0] exp);
      vectors++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s at t=%0t: got seg=%h an=%h, expected seg=%h an=%h",
                  name, $time, act[10:4], act[3:0], exp[10:4], exp[3:0]);
      end
   endtask

   task automatic model_reset();
      cyc = 0;
      for (int i = 0; i < 4; i++) snap[i] = 4'h0;
   endtask

   // Apply one cycle of inputs, advance the model, and compare after the edge.
   task automatic step(input logic ld, input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] s, input logic [3:0] d, input logic bl);
      logic [10:0] exp;
      load = ld; a_in = a; b_in = b; sum_in = s; diff_in = d; blank = bl;
      exp = model_out(cyc, bl);
      if (ld) begin
         snap[0] = d; snap[1] = s; snap[2] = b; snap[3] = a;
      end
      last_c = cyc;
      cyc++;
      @(posedge clk);
      #1;
      got_seg = seg;
      got_an  = an;
      chk("model", {seg, an}, exp);
   endtask

   task automatic rnd_step(input logic ld, input logic bl);
      step(ld, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
           4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), bl);
   endtask

   logic [3:0] an_lit  [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
   logic [6:0] seg_lit [4] = '{7'h06, 7'h00, 7'h12, 7'h30};

   initial begin
      clk = 1'b0; rst_n = 1'b0; load = 1'b0; blank = 1'b0;
      a_in = 4'h0; b_in = 4'h0; sum_in = 4'h0; diff_in = 4'h0;
      vectors = 0; errs = 0;
      model_reset();
      #12;
      chk("reset_state", {seg, an}, {7'h7F, 4'hF});
      @(negedge clk);
      rst_n = 1'b1;

      // Load 3/5/8/E on the first edge, then one full scan with literal checks.
      step(1'b1, 4'h3, 4'h5, 4'h8, 4'hE, 1'b0);
      for (int i = 1; i <= 16; i++) begin
         rnd_step(1'b0, 1'b0);
         if (i % 4 == 0) chk("scan_dark", {got_seg, got_an}, {7'h7F, 4'hF});
         else chk("scan_lit", {got_seg, got_an}, {seg_lit[(i / 4) % 4], an_lit[(i / 4) % 4]});
      end

      // Asynchronous reset mid-slot: outputs go dark with no clock edge.
      rnd_step(1'b0, 1'b0);
      rnd_step(1'b0, 1'b0);
      #2 rst_n = 1'b0;
      #1 chk("async_reset", {seg, an}, {7'h7F, 4'hF});
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      for (int i = 0; i < 4; i++) begin
         step(1'b0, 4'h9, 4'h9, 4'h9, 4'h9, 1'b0);
         if (i == 1) chk("post_reset_digit0", {got_seg, got_an}, {7'h40, 4'hE});
      end

      // Hex sweep through digit 0.
      for (int v = 0; v < 16; v++) begin
         while (cyc % 16 != 0) rnd_step(1'b0, 1'b0);
         step(1'b1, 4'h0, 4'h0, 4'h0, 4'(v), 1'b0);
         step(1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
         chk("hex_sweep", {got_seg, got_an}, {~dec_tab[v], 4'hE});
      end

      // Blank for 10 cycles starting mid-slot; scan keeps moving.
      step(1'b1, 4'h3, 4'h5, 4'h8, 4'hE, 1'b0);
      while (cyc % 4 != 2) rnd_step(1'b0, 1'b0);
      for (int i = 0; i < 10; i++) begin
         rnd_step(1'b0, 1'b1);
         chk("blank", {got_seg, got_an}, {7'h7F, 4'hF});
      end
      for (int i = 0; i < 8; i++) rnd_step(1'b0, 1'b0);

      // Load exactly on the digit 0 -> 1 tick edge, sum 8 -> 1.
      while (cyc % 16 != 3) rnd_step(1'b0, 1'b0);
      step(1'b1, 4'h3, 4'h5, 4'h1, 4'hE, 1'b0);
      step(1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         rnd_step(1'b0, 1'b0);
         chk("tick_load", {got_seg, got_an}, {7'h79, 4'hD});
      end

      // Inputs toggling with load low must not disturb the display.
      for (int i = 0; i < 32; i++) begin
         rnd_step(1'b0, 1'b0);
         if (last_c % 16 == 9) chk("hold_b", {got_seg, got_an}, {7'h12, 4'hB});
      end

      // Free-running random traffic.
      for (int i = 0; i < 400; i++) begin
         rnd_step(($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end

endmodule
